// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared types and default sizing for the fabric configuration loader
package fpga_cfg_pkg;

    localparam int FPGA_CFG_W      = 224;
    localparam int FPGA_NUM_ROWS   = 43;
    localparam int FPGA_SETTLE_CYC = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LOAD,
        ST_WRITE,
        ST_POST,
        ST_ARM,
        ST_DONE
    } cfg_state_t;

    // Settle counter must hold SETTLE_CYC itself and never collapse to zero width.
    function automatic int settle_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fpga_cfg_settle_timer.sv
// rtl/fpga_cfg_settle_timer.sv - loadable down-counter with zero flag for the settle phases
module fpga_cfg_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - streams NUM_ROWS config words into the fabric one row strobe at a time
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CFG_W      = FPGA_CFG_W,
    parameter int NUM_ROWS   = FPGA_NUM_ROWS,
    parameter int SETTLE_CYC = FPGA_SETTLE_CYC
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                start,
    input  logic                cfg_valid,
    input  logic [CFG_W-1:0]    cfg_data,
    input  logic                cfg_last,
    output logic                cfg_ready,
    output logic [CFG_W-1:0]    configs_in,
    output logic [NUM_ROWS-1:0] configs_en,
    output logic                ff_en,
    output logic                rdy,
    output logic                busy,
    output logic                err_len
);

    localparam int               ROW_W    = $clog2(NUM_ROWS + 1);
    localparam int               CNT_W    = settle_cnt_w(SETTLE_CYC);
    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYC);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    cfg_state_t       state_q, state_d;
    logic [ROW_W-1:0] row_q;

    logic tmr_load, tmr_dec, tmr_zero;
    logic row_clr, row_inc, capture, set_ff, set_rdy, clr_flags;
    logic transfer;

    assign cfg_ready = (state_q == ST_LOAD);
    assign transfer  = cfg_valid && cfg_ready;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

    fpga_cfg_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle (
        .clock    (clock),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SETTLE_V),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        row_clr   = 1'b0;
        row_inc   = 1'b0;
        capture   = 1'b0;
        set_ff    = 1'b0;
        set_rdy   = 1'b0;
        clr_flags = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PRE;
                    tmr_load  = 1'b1;
                    row_clr   = 1'b1;
                    clr_flags = 1'b1;
                end
            end
            ST_PRE: begin
                if (tmr_zero) begin
                    state_d = ST_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_LOAD: begin
                if (transfer) begin
                    capture = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                row_inc = 1'b1;
                // err_len was raised at this word's transfer, so it doubles as the abort flag
                if (err_len) begin
                    state_d = ST_IDLE;
                end else if (row_q == LAST_ROW) begin
                    state_d  = ST_POST;
                    tmr_load = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_POST: begin
                if (tmr_zero) begin
                    state_d = ST_ARM;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ARM: begin
                set_ff  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_PRE;
                    tmr_load  = 1'b1;
                    row_clr   = 1'b1;
                    clr_flags = 1'b1;
                end else begin
                    set_rdy = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            row_q      <= '0;
            configs_in <= '0;
            err_len    <= 1'b0;
            ff_en      <= 1'b0;
            rdy        <= 1'b0;
        end else begin
            if (row_clr) begin
                row_q <= '0;
            end else if (row_inc) begin
                row_q <= row_q + ROW_W'(1);
            end
            if (capture) begin
                configs_in <= cfg_data;
            end
            if (clr_flags) begin
                err_len <= 1'b0;
                ff_en   <= 1'b0;
                rdy     <= 1'b0;
            end else begin
                if (capture && (cfg_last != (row_q == LAST_ROW))) begin
                    err_len <= 1'b1;
                end
                if (set_ff) begin
                    ff_en <= 1'b1;
                end
                if (set_rdy) begin
                    rdy <= 1'b1;
                end
            end
        end
    end

    // One-hot strobe decoded straight from the state so it is exactly one WRITE cycle wide.
    always_comb begin
        configs_en = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            configs_en[i] = (state_q == ST_WRITE) && (row_q == ROW_W'(i));
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - directed self-checking bench for fpga_cfg_loader
module tb_fpga_cfg_loader;

    localparam int CFG_W      = 8;
    localparam int NUM_ROWS   = 4;
    localparam int SETTLE_CYC = 3;

    logic                clock = 1'b0;
    logic                rst;
    logic                start;
    logic                cfg_valid;
    logic [CFG_W-1:0]    cfg_data;
    logic                cfg_last;
    logic                cfg_ready;
    logic [CFG_W-1:0]    configs_in;
    logic [NUM_ROWS-1:0] configs_en;
    logic                ff_en;
    logic                rdy;
    logic                busy;
    logic                err_len;

    int total = 0;
    int bad   = 0;

    logic [7:0] wd [0:7];
    logic [3:0] lastm;
    logic [7:0] vpat;
    int         widx;
    int         cyc;
    int         nstr;
    int         n;
    logic       xfer;
    logic [3:0] exp_en;

    fpga_cfg_loader #(
        .CFG_W      (CFG_W),
        .NUM_ROWS   (NUM_ROWS),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .cfg_ready  (cfg_ready),
        .configs_in (configs_in),
        .configs_en (configs_en),
        .ff_en      (ff_en),
        .rdy        (rdy),
        .busy       (busy),
        .err_len    (err_len)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        cfg_valid = vpat[cyc[2:0]] && (widx < 4);
        cfg_data  = (widx < 4) ? wd[widx] : 8'h00;
        cfg_last  = (widx < 4) ? lastm[widx] : 1'b0;
    endtask

    task automatic tick();
        xfer = cfg_valid && cfg_ready;
        @(posedge clock);
        #1;
        cyc++;
        if (xfer) widx++;
        drive_src();
    endtask

    task automatic do_start();
        widx  = 0;
        drive_src();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_words(input int budget);
        int k;
        k    = 0;
        nstr = 0;
        while (busy && k < budget) begin
            if (configs_en !== '0) begin
                chk("strobe_onehot", configs_en, 32'(1 << nstr));
                chk("strobe_data", configs_in, wd[nstr & 7]);
                chk("strobe_ready", cfg_ready, 0);
                chk("strobe_after_xfer", widx > nstr, 1);
                nstr++;
            end
            tick();
            k++;
        end
        chk("run_in_budget", k < budget, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, cfg_ready, 0);
        chk({tag, "_cin"}, configs_in, 0);
        chk({tag, "_en"}, configs_en, 0);
        chk({tag, "_ff"}, ff_en, 0);
        chk({tag, "_rdy"}, rdy, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_len, 0);
    endtask

    initial begin
        wd[0] = 8'hA1; wd[1] = 8'hB2; wd[2] = 8'hC3; wd[3] = 8'hD4;
        wd[4] = 8'h00; wd[5] = 8'h00; wd[6] = 8'h00; wd[7] = 8'h00;
        cyc = 0; widx = 0; lastm = 4'b1000; vpat = 8'hFF;
        rst = 1'b1; start = 1'b0;
        drive_src();
        tick(); tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // 1: nominal load, cycle-exact timeline from the start edge (k=1)
        do_start();
        for (int k = 1; k <= 20; k++) begin
            case (k)
                6:       exp_en = 4'b0001;
                8:       exp_en = 4'b0010;
                10:      exp_en = 4'b0100;
                12:      exp_en = 4'b1000;
                default: exp_en = 4'b0000;
            endcase
            chk($sformatf("nom_en_k%0d", k), configs_en, exp_en);
            chk($sformatf("nom_ready_k%0d", k), cfg_ready, (k == 5 || k == 7 || k == 9 || k == 11));
            chk($sformatf("nom_ff_k%0d", k), ff_en, k >= 18);
            chk($sformatf("nom_rdy_k%0d", k), rdy, k >= 19);
            if (k == 6)  chk("nom_cin_a1", configs_in, 8'hA1);
            if (k == 8)  chk("nom_cin_b2", configs_in, 8'hB2);
            if (k == 10) chk("nom_cin_c3", configs_in, 8'hC3);
            if (k == 12) chk("nom_cin_d4", configs_in, 8'hD4);
            tick();
        end
        chk("nom_err", err_len, 0);
        chk("nom_busy", busy, 0);

        // 2: gappy source
        vpat = 8'b1001_0110;
        do_start();
        run_words(200);
        chk("gap_nstr", nstr, 4);
        chk("gap_ff", ff_en, 1);
        chk("gap_err", err_len, 0);
        tick();
        chk("gap_rdy", rdy, 1);

        // 3: last flagged on the second word
        vpat = 8'hFF; lastm = 4'b0010;
        do_start();
        run_words(200);
        chk("early_nstr", nstr, 2);
        chk("early_err", err_len, 1);
        chk("early_ff", ff_en, 0);
        chk("early_rdy", rdy, 0);
        chk("early_idle_ready", cfg_ready, 0);

        // 4: last never flagged, then a clean reload
        lastm = 4'b0000;
        do_start();
        run_words(200);
        chk("miss_nstr", nstr, 4);
        chk("miss_err", err_len, 1);
        chk("miss_ff", ff_en, 0);
        tick(); tick();
        chk("miss_rdy", rdy, 0);
        lastm = 4'b1000;
        do_start();
        chk("miss_err_clr", err_len, 0);
        run_words(200);
        chk("reload_nstr", nstr, 4);
        tick();
        chk("reload_rdy", rdy, 1);
        chk("reload_err", err_len, 0);

        // 5: reset during the third row write
        do_start();
        n = 0;
        while (configs_en !== 4'b0100 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_found_write3", configs_en, 4'b0100);
        #2 rst = 1'b1;
        #1;
        chk_zero("midrst");
        rst = 1'b0;
        tick();
        do_start();
        run_words(200);
        chk("postrst_nstr", nstr, 4);
        tick();
        chk("postrst_rdy", rdy, 1);

        // 6: start while loading is ignored; start in DONE restarts
        vpat = 8'h00;
        do_start();
        n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        chk("mid_in_load", cfg_ready, 1);
        vpat  = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_busy", busy, 1);
        chk("mid_still_load", cfg_ready, 1);
        run_words(200);
        chk("mid_nstr", nstr, 4);
        chk("mid_ff", ff_en, 1);
        tick();
        chk("mid_rdy", rdy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_restart_ff", ff_en, 0);
        chk("done_restart_rdy", rdy, 0);
        chk("done_restart_busy", busy, 1);
        chk("done_restart_pre", cfg_ready, 0);
        tick(); tick(); tick();
        chk("done_restart_pre4", cfg_ready, 0);
        tick();
        chk("done_restart_load", cfg_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
